dmem_responder: RTL and testbench

Data-memory responder for the pipelined RV32 core: the target end of the core's load/store request interface. It accepts one word-aligned read or write request at a time through a valid/ready handshake. It waits a fixed programmable latency, then returns a response (read data or write acknowledgement plus error flag) through a second valid/ready handshake. It sits beside `Pipeline_top` in the system and replaces the zero-latency data memory, so the core's stall logic can be exercised.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/dmem_array.sv | 44 ++++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the data-memory responder and its RAM.
// Contents:
//   state_t        responder FSM states (IDLE, WAIT, RESP)
//   LATENCY_MIN/MAX legal range of the response latency
//   CNT_WIDTH      width of the latency down-counter
//   BE_WIDTH       number of byte lanes in a data word
//   DATA_WIDTH     data word width
//   addr_error()   misalignment / out-of-range check for a byte address
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 7;
    localparam int CNT_WIDTH   = 3;
    localparam int BE_WIDTH    = 4;
    localparam int DATA_WIDTH  = 32;

    // A request is in error when it is not word aligned or when its word
    // index does not fit in the memory. The whole upper address is checked,
    // so high addresses never alias onto low words.
    function automatic logic addr_error(input logic [31:0] addr,
                                        input int addr_width);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_width + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// Single-port synchronous RAM, 2^ADDR_WIDTH words of 32 bits, with per-byte
// write enables and a registered read. Contents are never reset.
// Ports:
//   clk    in   clock
//   en     in   access enable for this cycle
//   we     in   1 = write enabled bytes, 0 = read into rdata
//   addr   in   word index
//   wdata  in   write data
//   be     in   byte enables, bit i selects wdata[8i+7:8i]
//   rdata  out  registered read data (holds between reads)
module dmem_array
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BE_WIDTH-1:0]   be,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // rdata only changes on a read access, so it stays stable while the
    // responder holds a pending response.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_WIDTH; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Target end of the core's load/store interface. Accepts one word-aligned
// request at a time, waits LATENCY cycles, then presents a response until the
// initiator takes it.
// Parameters:
//   ADDR_WIDTH  word-address bits (memory depth 2^ADDR_WIDTH words)
//   LATENCY     cycles from request acceptance to rsp_valid, 1..7
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address
//   req_wdata  in   write data
//   req_be     in   byte enables (ignored for reads)
//   rsp_valid  out  response present
//   rsp_ready  in   initiator accepts the response
//   rsp_rdata  out  read data, 0 for writes and errors
//   rsp_err    out  request was misaligned or out of range
module dmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("dmem_responder: LATENCY must lie in 1..7");
    end

    state_t                state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  we_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic                  rd_sel;

    logic                  commit;
    logic                  cur_we;
    logic [31:0]           cur_addr;
    logic [31:0]           cur_wdata;
    logic [BE_WIDTH-1:0]   cur_be;
    logic                  cur_err;
    logic                  ram_en;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // With LATENCY==1 the commit edge is the acceptance edge, so the request
    // registers are not loaded yet and the live request fields are used.
    // Reset suppresses any memory access on the edge it is sampled.
    always_comb begin
        cur_we    = (state == IDLE) ? req_we    : we_q;
        cur_addr  = (state == IDLE) ? req_addr  : addr_q;
        cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
        cur_be    = (state == IDLE) ? req_be    : be_q;
        cur_err   = addr_error(cur_addr, ADDR_WIDTH);
        commit    = ((state == WAIT) && (cnt == '0)) ||
                    ((state == IDLE) && req_valid && req_ready && (LATENCY == 1));
        ram_en    = commit && !cur_err && !rst;
    end

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (cur_we),
        .addr  (cur_addr[ADDR_WIDTH+1:2]),
        .wdata (cur_wdata),
        .be    (cur_be),
        .rdata (ram_rdata)
    );

    // The RAM read register holds its word while no new read is issued, so
    // gating it with a registered select gives a stable, reset-clean rsp_rdata.
    assign rsp_rdata = rd_sel ? ram_rdata : 32'd0;

    // Request/response FSM. The commit block after the case overrides the
    // state transition on the edge the memory access happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rd_sel    <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        be_q      <= req_be;
                        cnt       <= CNT_WIDTH'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_WIDTH'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
            if (commit) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= cur_err;
                rd_sel    <= !cur_we && !cur_err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Drives two responders (LATENCY=2 and LATENCY=4) that share request fields;
// cur_sel picks which one gets req_valid and whose outputs are observed.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        rsp_ready = 1'b0;
    bit          cur_sel = 1'b0;

    logic        req_ready_a, rsp_valid_a, rsp_err_a;
    logic [31:0] rsp_rdata_a;
    logic        req_ready_b, rsp_valid_b, rsp_err_b;
    logic [31:0] rsp_rdata_b;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int total = 0;
    int bad = 0;

    logic [31:0] model_mem [2][32];

    typedef struct {
        bit          sel;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [16];

    assign req_ready = cur_sel ? req_ready_b : req_ready_a;
    assign rsp_valid = cur_sel ? rsp_valid_b : rsp_valid_a;
    assign rsp_err   = cur_sel ? rsp_err_b   : rsp_err_a;
    assign rsp_rdata = cur_sel ? rsp_rdata_b : rsp_rdata_a;

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid && !cur_sel),
        .req_ready (req_ready_a),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid_a),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata_a),
        .rsp_err   (rsp_err_a)
    );

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid && cur_sel),
        .req_ready (req_ready_b),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid_b),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata_b),
        .rsp_err   (rsp_err_b)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard time limit in case a wait never resolves
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit sel, input bit we,
                                 input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 input logic [3:0] be);
        cur_sel   = sel;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_valid = 1'b1;
    endtask

    // Counts edges from acceptance until rsp_valid is seen (bounded)
    task automatic waitRsp(output int n);
        n = 0;
        while (!rsp_valid && n < 20) begin
            checkOutput("req_ready_wait", 32'(req_ready), 32'd0);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
        checkOutput("req_ready_after_hs", 32'(req_ready), 32'd1);
    endtask

    task automatic runTxn(input bit sel, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int hold, output logic [31:0] rd,
                          output logic er);
        int n;
        int lat;
        lat = sel ? 4 : 2;
        applyStimulus(sel, we, addr, wdata, be);
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        waitRsp(n);
        checkOutput("latency", 32'(n), 32'(lat));
        rd = rsp_rdata;
        er = rsp_err;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_rdata", rsp_rdata, rd);
            checkOutput("hold_err", 32'(rsp_err), 32'(er));
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
        end
        handshake();
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [3:0]  be;
        bit          sel;
        bit          we;
        bit          exp_er;
        int          n;
        int          kind;
        int          w;

        vecs[0]  = '{0, 1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 32'h0,        0};
        vecs[1]  = '{0, 0, 32'h10,       32'h0,        4'hF, 0, 32'hDEADBEEF, 0};
        vecs[2]  = '{0, 1, 32'h10,       32'h00AA5500, 4'h6, 1, 32'h0,        0};
        vecs[3]  = '{0, 0, 32'h10,       32'h0,        4'h0, 2, 32'hDEAA55EF, 0};
        vecs[4]  = '{0, 0, 32'h13,       32'h0,        4'hF, 0, 32'h0,        1};
        vecs[5]  = '{0, 1, 32'h0,        32'h12345678, 4'hF, 0, 32'h0,        0};
        vecs[6]  = '{0, 1, 32'h1000,     32'hFFFFFFFF, 4'hF, 0, 32'h0,        1};
        vecs[7]  = '{0, 0, 32'h0,        32'h0,        4'hF, 0, 32'h12345678, 0};
        vecs[8]  = '{0, 1, 32'hFFC,      32'hCAFEF00D, 4'hF, 0, 32'h0,        0};
        vecs[9]  = '{0, 0, 32'hFFC,      32'h0,        4'hF, 0, 32'hCAFEF00D, 0};
        vecs[10] = '{0, 0, 32'h80000010, 32'h0,        4'hF, 0, 32'h0,        1};
        vecs[11] = '{0, 1, 32'h12,       32'h11111111, 4'hF, 0, 32'h0,        1};
        vecs[12] = '{0, 1, 32'h10,       32'h99999999, 4'h0, 0, 32'h0,        0};
        vecs[13] = '{0, 0, 32'h10,       32'h0,        4'hF, 0, 32'hDEAA55EF, 0};
        vecs[14] = '{1, 1, 32'h20,       32'h11112222, 4'hF, 0, 32'h0,        0};
        vecs[15] = '{1, 0, 32'h20,       32'h0,        4'hF, 0, 32'h11112222, 0};

        // Reset for two cycles, then check idle outputs of both instances
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            cur_sel = bit'(s);
            #1;
            checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
            checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
            checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        end
        cur_sel = 1'b0;
        @(negedge clk);

        // rsp_ready while idle does nothing
        rsp_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("idle_ready_valid", 32'(rsp_valid), 32'd0);
            checkOutput("idle_ready_req_ready", 32'(req_ready), 32'd1);
        end
        rsp_ready = 1'b0;

        $display("[TB] directed vectors");
        for (int i = 0; i < 16; i++) begin
            runTxn(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].be, vecs[i].hold, rd, er);
            checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        $display("[TB] backpressure with a second pending request");
        applyStimulus(0, 0, 32'h10, 32'h0, 4'hF);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(0, 0, 32'hFFC, 32'h0, 4'hF);
        waitRsp(n);
        checkOutput("bp_latency", 32'(n), 32'd2);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rdata", rsp_rdata, 32'hDEAA55EF);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
        end
        handshake();
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("bp2_req_ready", 32'(req_ready), 32'd0);
        waitRsp(n);
        checkOutput("bp2_latency", 32'(n), 32'd2);
        checkOutput("bp2_rdata", rsp_rdata, 32'hCAFEF00D);
        handshake();

        $display("[TB] reset during WAIT (LATENCY=4)");
        applyStimulus(1, 1, 32'h20, 32'hBAD0BAD0, 4'hF);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstwait_req_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            checkOutput("rstwait_no_valid", 32'(rsp_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        runTxn(1, 0, 32'h20, 32'h0, 4'hF, 0, rd, er);
        checkOutput("rstwait_old_data", rd, 32'h11112222);

        $display("[TB] reset during RESP keeps committed write");
        applyStimulus(0, 1, 32'h24, 32'h00000055, 4'hF);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        waitRsp(n);
        checkOutput("rstresp_latency", 32'(n), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstresp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rstresp_req_ready", 32'(req_ready), 32'd1);
        runTxn(0, 0, 32'h24, 32'h0, 4'hF, 0, rd, er);
        checkOutput("rstresp_data", rd, 32'h00000055);

        $display("[TB] reset coincident with acceptance");
        runTxn(0, 1, 32'h28, 32'h01010101, 4'hF, 0, rd, er);
        applyStimulus(0, 1, 32'h28, 32'h77777777, 4'hF);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        checkOutput("rstacc_req_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("rstacc_no_valid", 32'(rsp_valid), 32'd0);
        end
        runTxn(0, 0, 32'h28, 32'h0, 4'hF, 0, rd, er);
        checkOutput("rstacc_data", rd, 32'h01010101);

        $display("[TB] preload model words");
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 32; i++) begin
                wdata = $urandom();
                runTxn(bit'(s), 1, 32'(i * 4), wdata, 4'hF, 0, rd, er);
                checkOutput("preload_err", 32'(er), 32'd0);
                model_mem[s][i] = wdata;
            end
        end

        $display("[TB] random traffic");
        for (int t = 0; t < 150; t++) begin
            sel   = bit'($urandom_range(0, 1));
            we    = bit'($urandom_range(0, 1));
            wdata = $urandom();
            be    = 4'($urandom_range(0, 15));
            kind  = $urandom_range(0, 9);
            w     = $urandom_range(0, 31);
            if (kind == 0) begin
                addr = 32'(w * 4 + $urandom_range(1, 3));
            end else if (kind == 1) begin
                addr = ($urandom() | 32'h00001000) & 32'hFFFFFFFC;
            end else begin
                addr = 32'(w * 4);
            end
            exp_er = (addr % 4 != 0) || (addr / 4 >= 1024);
            exp_rd = 32'd0;
            if (!exp_er) begin
                if (we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) begin
                            model_mem[sel][addr / 4][8*b +: 8] = wdata[8*b +: 8];
                        end
                    end
                end else begin
                    exp_rd = model_mem[sel][addr / 4];
                end
            end
            runTxn(sel, we, addr, wdata, be, $urandom_range(0, 3), rd, er);
            checkOutput("rand_rdata", rd, exp_rd);
            checkOutput("rand_err", 32'(er), 32'(exp_er));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
